// File: rtl/ctrl_frame_pkg.sv
// Shared constants, state encoding and helpers for the FPRI/code control frame encoder.
package ctrl_frame_pkg;

  localparam logic [7:0] HDR1 = 8'hAA;
  localparam logic [7:0] HDR2 = 8'h55;
  localparam int NUM_BYTES  = 21;
  localparam int PAD_BYTES  = 1;
  localparam int BIT_CYC    = 4;
  localparam int PRI_DELAY  = 2000;
  localparam int MIN_PERIOD = 2100;
  localparam int FRAME_BITS = (NUM_BYTES + PAD_BYTES) * 8;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  typedef logic [NUM_BYTES-1:0][7:0] frame_bytes_t;

  // Spacing between FPRI falls: the programmed period only applies while auto-repeat is on.
  function automatic logic [15:0] clamp_period(input logic auto_en, input logic [15:0] period);
    if (auto_en && (period > 16'(MIN_PERIOD)))
      return period;
    return 16'(MIN_PERIOD);
  endfunction

endpackage

// File: rtl/ctrl_frame_encode_if.sv
// Control-word inputs and frame outputs of the encoder, bundled for the top-level port list.
interface ctrl_frame_encode_if;
  import ctrl_frame_pkg::*;

  // start is a 1-cycle request with no ready: it is always accepted into the one-deep pending
  // slot while a frame is in flight, and overrun pulses when it is dropped because the slot is full.
  logic        start;
  logic        auto_en;
  logic [15:0] period;
  logic [7:0]  work_mode, ver_code, wave_code, fre_code, pri_code;
  logic [7:0]  hor1_code, hor2_code, hor3_code, pulse_mode, monitor_addr, monitor_mode;
  logic [15:0] hor_phase_R, ver_phase_R, hor_phase_T, ver_phase_T;
  logic        FPRI;
  logic        code;
  logic        busy;
  logic        done;
  logic        overrun;
  state_t      state;

  modport master (
    output start, auto_en, period, work_mode, ver_code, wave_code, fre_code, pri_code,
           hor1_code, hor2_code, hor3_code, pulse_mode, monitor_addr, monitor_mode,
           hor_phase_R, ver_phase_R, hor_phase_T, ver_phase_T,
    input  FPRI, code, busy, done, overrun, state
  );

  modport slave (
    input  start, auto_en, period, work_mode, ver_code, wave_code, fre_code, pri_code,
           hor1_code, hor2_code, hor3_code, pulse_mode, monitor_addr, monitor_mode,
           hor_phase_R, ver_phase_R, hor_phase_T, ver_phase_T,
    output FPRI, code, busy, done, overrun, state
  );

endinterface

// File: rtl/ctrl_frame_shift.sv
// Frame serialiser: snapshots the frame bytes, then shifts them out MSB-first at BIT_CYC clocks/bit.
module ctrl_frame_shift
  import ctrl_frame_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  frame_bytes_t bytes,
  output logic         fpri,
  output logic         code,
  output logic         done,
  output logic         last
);

  frame_bytes_t snap;
  logic [1:0]   phase;
  logic [7:0]   bit_idx;
  logic [4:0]   byte_sel;
  logic [2:0]   bit_sel;
  logic [7:0]   cur_byte;

  assign byte_sel = bit_idx[7:3];
  assign bit_sel  = 3'd7 - bit_idx[2:0];
  assign last     = run && (bit_idx == 8'(FRAME_BITS));

  // Indices past the snapshot are the pad byte.
  always_comb begin
    cur_byte = 8'h00;
    if (byte_sel < 5'(NUM_BYTES))
      cur_byte = snap[byte_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      phase   <= '0;
      bit_idx <= '0;
      fpri    <= 1'b1;
      code    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        snap    <= bytes;
        phase   <= '0;
        bit_idx <= '0;
      end else if (last) begin
        fpri <= 1'b1;
        code <= 1'b0;
        done <= 1'b1;
      end else if (run) begin
        fpri <= 1'b0;
        if (phase == 2'd0)
          code <= cur_byte[bit_sel];
        if (phase == 2'(BIT_CYC - 1)) begin
          phase   <= '0;
          bit_idx <= bit_idx + 8'd1;
        end else begin
          phase <= phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ctrl_frame_encode.sv
// Radar control frame encoder: launch FSM, pending/overrun tracking and frame-to-frame spacing.
module ctrl_frame_encode
  import ctrl_frame_pkg::*;
(
  input logic               glb_100M,
  input logic               rst,
  ctrl_frame_encode_if.slave bus
);

  state_t       state;
  logic         pending;
  logic         busy_q;
  logic         overrun_q;
  logic         load_q;
  logic [15:0]  frame_cnt;
  logic [15:0]  t_next;
  logic         launch_gap;
  logic         gap_end;
  logic         last;
  logic         fpri;
  logic         code;
  logic         done;
  frame_bytes_t bytes;

  always_comb begin
    bytes     = '0;
    bytes[0]  = HDR1;
    bytes[1]  = HDR2;
    bytes[2]  = bus.work_mode;
    bytes[3]  = bus.ver_code;
    bytes[4]  = bus.wave_code;
    bytes[5]  = bus.fre_code;
    bytes[6]  = bus.pri_code;
    bytes[7]  = bus.hor1_code;
    bytes[8]  = bus.hor2_code;
    bytes[9]  = bus.hor3_code;
    bytes[10] = bus.pulse_mode;
    bytes[11] = bus.monitor_addr;
    bytes[12] = bus.monitor_mode;
    bytes[13] = bus.hor_phase_R[7:0];
    bytes[14] = bus.hor_phase_R[15:8];
    bytes[15] = bus.ver_phase_R[7:0];
    bytes[16] = bus.ver_phase_R[15:8];
    bytes[17] = bus.hor_phase_T[7:0];
    bytes[18] = bus.hor_phase_T[15:8];
    bytes[19] = bus.ver_phase_T[7:0];
    bytes[20] = bus.ver_phase_T[15:8];
  end

  // frame_cnt holds k-1 at edge E0+k; relaunching three edges early puts the next E0 exactly at Tnext.
  assign t_next     = clamp_period(bus.auto_en, bus.period);
  assign launch_gap = (frame_cnt >= t_next - 16'd3) && (pending || bus.auto_en || bus.start);
  assign gap_end    = (frame_cnt >= t_next - 16'd1);

  always_ff @(posedge glb_100M or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      load_q    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      overrun_q <= 1'b0;
      load_q    <= (state == LOAD);
      if (load_q)
        frame_cnt <= '0;
      else if (frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (bus.start || bus.auto_en) begin
            state  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD, SEND: begin
          if (state == LOAD)
            state <= SEND;
          else if (last)
            state <= GAP;
          if (bus.start) begin
            if (pending) overrun_q <= 1'b1;
            else         pending   <= 1'b1;
          end
        end
        GAP: begin
          if (launch_gap) begin
            // A start arriving with the relaunch is consumed unless an older one is being used up.
            state   <= LOAD;
            pending <= pending & bus.start;
          end else if (gap_end) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.start) begin
            if (pending) overrun_q <= 1'b1;
            else         pending   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ctrl_frame_shift u_shift (
    .clk   (glb_100M),
    .rst   (rst),
    .load  (state == LOAD),
    .run   (state == SEND),
    .bytes (bytes),
    .fpri  (fpri),
    .code  (code),
    .done  (done),
    .last  (last)
  );

  assign bus.FPRI    = fpri;
  assign bus.code    = code;
  assign bus.done    = done;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign bus.state   = state;

endmodule
